frv_mem_responder: RTL and testbench



---
 rtl/frv_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_frv_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/frv_mem_responder.sv
// frv_mem_responder: single-port memory responder for a core's data/instruction bus.
// Configurable grant latency; 1-cycle read data; byte-strobed writes; address error
// checking against a BASE_ADDR/DEPTH window.
//
// Optional feature: define FRV_MEM_RESPONDER_STALL_EN to add pseudo-random grant
// stalls driven by an 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1).
//
// Ports:
//   g_clk      in   clock, all state on rising edge
//   g_reset    in   asynchronous active-high reset
//   mem_req    in   request pending
//   mem_wen    in   1 = write, 0 = read
//   mem_strb   in   [3:0] byte write strobe
//   mem_wdata  in   [31:0] write data
//   mem_addr   in   [31:0] byte address
//   mem_gnt    out  request accepted this cycle (combinational)
//   mem_error  out  error status of last accepted request (registered)
//   mem_rdata  out  [31:0] read data of last accepted request (registered)
module frv_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_MAX = 4'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_stall;
  logic        w_accept;
  logic        w_err;
  logic [29:0] w_word;
  logic [AW-1:0] w_idx;

  logic [31:0] r_mem [DEPTH];

`ifdef FRV_MEM_RESPONDER_STALL_EN
  // Free-running stall generator; a set LSB blocks the grant this cycle.
  logic [7:0] r_lfsr;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
    end
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // Word offset from the window base; unsigned wrap makes below-base addresses fault.
  assign w_word   = 30'((mem_addr - BASE_ADDR) >> 2);
  assign w_idx    = w_word[AW-1:0];
  assign w_err    = (mem_addr[1:0] != 2'b00) || ({2'b00, w_word} >= 32'(DEPTH));
  assign w_accept = mem_req && mem_gnt;

  // FSM state register
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant latency FSM; the counter saturates at WAIT_MAX while stalled.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mem_gnt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          if (WAIT_CYCLES == 0) begin
            mem_gnt = !w_stall;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!mem_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == WAIT_MAX) begin
          if (!w_stall) begin
            mem_gnt     = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    if (g_reset) begin
      mem_gnt = 1'b0;
    end
  end

  // Backing store: byte-strobed writes, intentionally not reset.
  always_ff @(posedge g_clk) begin
    if (w_accept && mem_wen && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_strb[b]) begin
          r_mem[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response registers: updated only on acceptance, held otherwise.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      mem_error <= 1'b0;
      mem_rdata <= 32'd0;
    end else if (w_accept) begin
      if (w_err) begin
        mem_error <= 1'b1;
        mem_rdata <= 32'd0;
      end else if (mem_wen) begin
        mem_error <= 1'b0;
      end else begin
        mem_error <= 1'b0;
        mem_rdata <= r_mem[w_idx];
      end
    end
  end

endmodule

// File: tb/tb_frv_mem_responder.sv
// Testbench for frv_mem_responder: two instances share the request inputs,
// one with zero wait cycles at base 0, one with three wait cycles at base 0x100.
module tb_frv_mem_responder;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        req;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] addr;

  logic        gnt0, err0, gnt3, err3;
  logic [31:0] rdata0, rdata3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 g_clk = ~g_clk;

  frv_mem_responder #(
    .DEPTH(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0), .LFSR_SEED(8'hA5)
  ) u_dut0 (
    .g_clk(g_clk), .g_reset(g_reset), .mem_req(req), .mem_wen(wen),
    .mem_strb(strb), .mem_wdata(wdata), .mem_addr(addr),
    .mem_gnt(gnt0), .mem_error(err0), .mem_rdata(rdata0)
  );

  frv_mem_responder #(
    .DEPTH(16), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(3), .LFSR_SEED(8'hA5)
  ) u_dut3 (
    .g_clk(g_clk), .g_reset(g_reset), .mem_req(req), .mem_wen(wen),
    .mem_strb(strb), .mem_wdata(wdata), .mem_addr(addr),
    .mem_gnt(gnt3), .mem_error(err3), .mem_rdata(rdata3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle.
  task automatic go(input logic r, input logic w, input logic [3:0] s,
                    input logic [31:0] d, input logic [31:0] a);
    @(negedge g_clk);
    req = r; wen = w; strb = s; wdata = d; addr = a;
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] m);
    return {1'b0, m[7:1]} ^ (m[0] ? 8'hB8 : 8'h00);
  endfunction

  initial begin
    g_reset = 1'b1; req = 1'b1; wen = 1'b0; strb = 4'h0; wdata = 32'd0; addr = 32'h10;
    repeat (2) @(negedge g_clk);
    #1;
    chk("rst_gnt0",   32'(gnt0), 32'd0);
    chk("rst_gnt3",   32'(gnt3), 32'd0);
    chk("rst_err0",   32'(err0), 32'd0);
    chk("rst_rdata0", rdata0,    32'd0);
    @(negedge g_clk);
    g_reset = 1'b0; req = 1'b0;

`ifdef FRV_MEM_RESPONDER_STALL_EN
    begin
      logic [7:0] m;
      int grants;
      int g3;
      m = 8'hA5; grants = 0; g3 = 0;
      for (int c = 0; c < 2000 && grants < 200; c++) begin
        m = lfsr_next(m);
        go(1'b1, 1'b0, 4'h0, 32'd0, 32'((grants % 16) * 4));
        chk("stall_gnt0", 32'(gnt0), 32'(!m[0]));
        if (gnt0) grants++;
        if (gnt3) g3++;
      end
      chk("stall_grants", 32'(grants), 32'd200);
      chk("stall_gnt3_seen", 32'(g3 != 0), 32'd1);
      go(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
      chk("stall_noreq0", 32'(gnt0), 32'd0);
      chk("stall_noreq3", 32'(gnt3), 32'd0);
    end
`else
    // Zero-wait instance: back-to-back accepts, read-after-write, strobes, errors.
    go(1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h10);
    chk("w10_gnt", 32'(gnt0), 32'd1);
    go(1'b1, 1'b0, 4'h0, 32'd0, 32'h10);
    chk("r10_gnt", 32'(gnt0), 32'd1);
    chk("w10_err", 32'(err0), 32'd0);
    chk("w10_rdata_keep", rdata0, 32'd0);
    go(1'b1, 1'b1, 4'hF, 32'h1122_3344, 32'h20);
    chk("r10_rdata", rdata0, 32'hDEAD_BEEF);
    chk("r10_err", 32'(err0), 32'd0);
    go(1'b1, 1'b1, 4'b0010, 32'h0000_AB00, 32'h20);
    chk("w20_rdata_keep", rdata0, 32'hDEAD_BEEF);
    go(1'b1, 1'b0, 4'h0, 32'd0, 32'h20);
    go(1'b1, 1'b0, 4'h0, 32'd0, 32'h2);
    chk("r20_partial", rdata0, 32'h1122_AB44);
    go(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h20);
    chk("r02_err", 32'(err0), 32'd1);
    chk("r02_rdata", rdata0, 32'd0);
    go(1'b1, 1'b0, 4'h0, 32'd0, 32'h40);
    chk("wstrb0_err", 32'(err0), 32'd0);
    chk("wstrb0_rdata", rdata0, 32'd0);
    go(1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h3C);
    chk("r40_err", 32'(err0), 32'd1);
    go(1'b1, 1'b0, 4'h0, 32'd0, 32'h3C);
    go(1'b1, 1'b0, 4'h0, 32'd0, 32'h20);
    chk("r3c_rdata", rdata0, 32'hCAFE_F00D);
    chk("r3c_err", 32'(err0), 32'd0);
    go(1'b0, 1'b0, 4'h0, 32'd0, 32'h20);
    chk("noreq_gnt0", 32'(gnt0), 32'd0);
    chk("r20_strb0_noop", rdata0, 32'h1122_AB44);
    go(1'b0, 1'b0, 4'h0, 32'd0, 32'h20);
    chk("hold_rdata0", rdata0, 32'h1122_AB44);

    // Three-wait instance: grant in exactly the fourth cycle of a held request.
    for (int k = 0; k < 4; k++) begin
      go(1'b1, 1'b1, 4'hF, 32'hA5A5_0001, 32'h104);
      chk($sformatf("w104_gnt_c%0d", k), 32'(gnt3), 32'(k == 3));
    end
    go(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    chk("w104_noreq", 32'(gnt3), 32'd0);
    chk("w104_err", 32'(err3), 32'd0);
    chk("w104_rdata", rdata3, 32'd0);

    // Request withdrawn in cycle 2: no grant, no store update.
    for (int k = 0; k < 2; k++) begin
      go(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h104);
      chk($sformatf("drop_gnt_c%0d", k), 32'(gnt3), 32'd0);
    end
    go(1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h104);
    chk("drop_gnt_c2", 32'(gnt3), 32'd0);
    for (int k = 0; k < 4; k++) begin
      go(1'b1, 1'b0, 4'h0, 32'd0, 32'h104);
      chk($sformatf("r104_gnt_c%0d", k), 32'(gnt3), 32'(k == 3));
    end
    go(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    chk("r104_rdata", rdata3, 32'hA5A5_0001);
    chk("r104_err", 32'(err3), 32'd0);

    // Below-base address wraps and faults.
    for (int k = 0; k < 4; k++) begin
      go(1'b1, 1'b0, 4'h0, 32'd0, 32'hFC);
      chk($sformatf("rfc_gnt_c%0d", k), 32'(gnt3), 32'(k == 3));
    end
    go(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    chk("rfc_err", 32'(err3), 32'd1);
    chk("rfc_rdata", rdata3, 32'd0);

    // Reset while a write is waiting aborts it.
    go(1'b1, 1'b1, 4'hF, 32'h0BAD_0BAD, 32'h104);
    go(1'b1, 1'b1, 4'hF, 32'h0BAD_0BAD, 32'h104);
    @(negedge g_clk);
    g_reset = 1'b1;
    #1;
    chk("rstw_gnt3", 32'(gnt3), 32'd0);
    chk("rstw_gnt0", 32'(gnt0), 32'd0);
    @(negedge g_clk);
    #1;
    chk("rstw_err3", 32'(err3), 32'd0);
    chk("rstw_rdata3", rdata3, 32'd0);
    chk("rstw_err0", 32'(err0), 32'd0);
    g_reset = 1'b0; req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      go(1'b1, 1'b0, 4'h0, 32'd0, 32'h104);
      chk($sformatf("postrst_gnt_c%0d", k), 32'(gnt3), 32'(k == 3));
    end
    go(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    chk("postrst_rdata", rdata3, 32'hA5A5_0001);
    chk("postrst_err", 32'(err3), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
